// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank and its per-channel counters.
package counter_bank_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  localparam int MAX_WIDTH = 64;

  // Saturation value for a counter of the given width (widths up to MAX_WIDTH).
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// One counter channel: priority clr > load > en, wrap or saturate on overflow,
// registered overflow pulse and a sticky overflow flag.
module counter_chan
  import counter_bank_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter cnt_mode_t        MODE  = CNT_WRAP,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf_pulse,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_pulse_q, ovf_pulse_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [WIDTH:0]   sum;
  logic             ovf_event;

  always_comb begin
    sum       = {1'b0, count_q} + {1'b0, step};
    count_d   = count_q;
    ovf_event = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      ovf_event = sum[WIDTH];
      if (MODE == CNT_SAT && sum[WIDTH]) begin
        count_d = MAX_VAL;
      end else begin
        count_d = sum[WIDTH-1:0];
      end
    end
    ovf_pulse_d  = ovf_event;
    // A new overflow outranks a simultaneous software clear of the flag.
    ovf_sticky_d = ovf_event | (ovf_sticky_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= INIT;
      ovf_pulse_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_pulse_q  <= ovf_pulse_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign count      = count_q;
  assign ovf_pulse  = ovf_pulse_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent counters; this level only packs and unpacks
// the per-channel buses around counter_chan instances.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 2,
  parameter cnt_mode_t        MODE     = CNT_WRAP,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0]          step,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       ovf_pulse,
  output logic [CHANNELS-1:0]       ovf_sticky
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    counter_chan #(
      .WIDTH(WIDTH),
      .MODE (MODE),
      .INIT (INIT)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .clr       (clr[i]),
      .load      (load[i]),
      .load_val  (load_val[i*WIDTH +: WIDTH]),
      .step      (step),
      .ovf_clr   (ovf_clr[i]),
      .count     (count[i*WIDTH +: WIDTH]),
      .ovf_pulse (ovf_pulse[i]),
      .ovf_sticky(ovf_sticky[i])
    );
  end

endmodule
